// File: rtl/aes_stream_pkg.sv
// rtl/aes_stream_pkg.sv - shared types and constants for the AES-128 stream controller
package aes_stream_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2
   } aes_state_e;

   localparam int AES_BLK_W    = 128;
   localparam int AES_CORE_LAT = 12;

endpackage

// File: rtl/aes_cipher_stream_ctrl.sv
// rtl/aes_cipher_stream_ctrl.sv - valid/ready front/back-end with watchdog for the iterative AES-128 core
module aes_cipher_stream_ctrl
   import aes_stream_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [AES_BLK_W-1:0] s_key,
   input  logic [AES_BLK_W-1:0] s_text,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [AES_BLK_W-1:0] m_text,
   output logic                 core_ld,
   output logic [AES_BLK_W-1:0] core_key,
   output logic [AES_BLK_W-1:0] core_text,
   input  logic                 core_done,
   input  logic [AES_BLK_W-1:0] core_text_out,
   output logic                 busy,
   output logic                 err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

   generate
      if (TIMEOUT < AES_CORE_LAT || TIMEOUT > 255) begin : g_bad_timeout
         $error("aes_cipher_stream_ctrl: TIMEOUT must lie in 12..255");
      end
   endgenerate

   aes_state_e           r_state;
   logic [CW-1:0]        r_wdog;
   logic [AES_BLK_W-1:0] r_key;
   logic [AES_BLK_W-1:0] r_text;
   logic [AES_BLK_W-1:0] r_m_text;
   logic                 r_m_valid;
   logic                 r_core_ld;
   logic                 r_busy;
   logic                 r_err;

   logic                 w_accept;
   logic                 w_m_take;
   logic [CW-1:0]        w_wdog_next;
   logic                 w_timeout;

   // The output slot is free or draining whenever we accept, so a result never waits on it.
   assign s_ready     = rst && (r_state == IDLE) && (!r_m_valid || m_ready);
   assign w_accept    = s_valid && s_ready;
   assign w_m_take    = r_m_valid && m_ready;
   // Count of WAIT cycles including the current one, saturating at the limit.
   assign w_wdog_next = (r_wdog == TIMEOUT_C) ? TIMEOUT_C : r_wdog + CW'(1);
   assign w_timeout   = (w_wdog_next == TIMEOUT_C);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_wdog    <= '0;
         r_key     <= '0;
         r_text    <= '0;
         r_m_text  <= '0;
         r_m_valid <= 1'b0;
         r_core_ld <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_core_ld <= 1'b0;
         if (w_m_take) begin
            r_m_valid <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_key     <= s_key;
                  r_text    <= s_text;
                  r_core_ld <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= LOAD;
               end
            end
            LOAD: begin
               r_wdog  <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               r_wdog <= w_wdog_next;
               if (core_done) begin
                  r_m_text  <= core_text_out;
                  r_m_valid <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= IDLE;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign m_valid   = r_m_valid;
   assign m_text    = r_m_text;
   assign core_ld   = r_core_ld;
   assign core_key  = r_key;
   assign core_text = r_text;
   assign busy      = r_busy;
   assign err       = r_err;

endmodule

// File: doc/aes_cipher_stream_ctrl.md
# aes_cipher_stream_ctrl

Streaming front/back-end for the iterative AES-128 encryption core. It accepts key+plaintext blocks on a valid/ready slave port and drives the core's one-cycle load strobe, holding key and text stable for the whole computation. It captures the ciphertext on the core's done pulse and presents it on a valid/ready master port. A watchdog flags a core that never signals done.

## Interface
- TIMEOUT, 16: maximum WAIT cycles before error; legal range 12..255.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- s_valid  in  1  input block valid.
- s_ready  out  1  input block accepted when s_valid & s_ready.
- s_key  in  128  cipher key, byte 0 in [127:120].
- s_text  in  128  plaintext, byte 0 in [127:120].
- m_valid  out  1  ciphertext valid.
- m_ready  in  1  downstream accepts ciphertext.
- m_text  out  128  ciphertext.
- core_ld  out  1  single-cycle load strobe to core.
- core_key  out  128  key to core, stable from load until result capture.
- core_text  out  128  plaintext to core, stable likewise.
- core_done  in  1  core completion pulse; core_text_out valid in the same cycle.
- core_text_out  in  128  core ciphertext.
- busy  out  1  high in LOAD or WAIT.
- err  out  1  sticky watchdog error.

## Operation
- FSM states are IDLE, LOAD and WAIT.
- IDLE:
  - s_ready = (!m_valid | m_ready).
  - On accept, register s_key/s_text into hold regs and go to LOAD.
  - core_done in IDLE is ignored.
- LOAD:
  - core_ld = 1 for exactly one cycle.
  - Clear the watchdog counter and go to WAIT unconditionally.
- WAIT:
  - Counter increments each cycle.
  - On core_done: m_text <= core_text_out, m_valid <= 1, go to IDLE.
  - If counter == TIMEOUT and !core_done: err <= 1, go to IDLE, no m_valid.
  - If core_done coincides with counter == TIMEOUT, done wins and no error is raised.
- Output slot:
  - m_valid clears on m_valid & m_ready.
  - The accept rule guarantees the slot is empty or being emptied when core_done arrives, so a result is never dropped and no second buffer is needed.
- core_key/core_text come straight from the hold regs and change only on accept.
- err clears only on reset. Operation continues normally after an error.
- The watchdog counter is $clog2(TIMEOUT+1) bits wide and saturates at TIMEOUT.

## Timing
- Reset values while rst = 0:
  - state IDLE.
  - s_ready 0, forced low while rst = 0.
  - m_valid 0, core_ld 0, busy 0, err 0.
  - m_text, core_key, core_text all 0.
- Accept at edge N:
  - LOAD occupies cycle N+1, with core_ld high.
  - The core asserts core_done 12 cycles after its ld cycle, i.e. cycle N+13.
  - m_valid rises in cycle N+14.
- Throughput: one block per 14 cycles when m_ready is held high. The next accept can occur in the first cycle m_valid is high.
- A back-pressured output (m_ready = 0) holds s_ready low. It never stalls an in-flight computation.
- Reset mid-WAIT: return to IDLE next cycle, with no m_valid and no err. The core shares rst and aborts as well.
- s_valid held without s_ready: inputs are ignored and no state change occurs.

## Structure
- Shared package aes_stream_pkg holds:
  - the state enum typedef (IDLE/LOAD/WAIT);
  - AES_BLK_W = 128;
  - AES_CORE_LAT = 12 (ld-to-done latency), used by the TIMEOUT legality assertion.
- Single module with no sub-module; the watchdog counter stays inline.
- Bench instantiates the block with the real core attached.

## Test plan
- FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> m_text 69c4e0d86a7b0430d8cdb78070b4c55a, m_valid exactly 14 cycles after accept.
- Back-to-back: 3 blocks with m_ready = 1 and s_valid always high -> accepts every 14 cycles, 3 correct results in order, core_ld pulses exactly 3 times.
- Back-pressure: m_ready = 0 for 40 cycles after first result -> m_valid/m_text held, s_ready = 0 throughout, next accept on the cycle m_ready rises.
- Watchdog: replace the core with a stub that never asserts done, TIMEOUT = 16 -> err = 1 in cycle accept+18, no m_valid, s_ready returns to 1.
- Done at boundary: stub asserts done exactly when counter == TIMEOUT -> result delivered, err stays 0.
- Reset in WAIT at cycle accept+6 -> m_valid never rises, err = 0, s_ready = 1 one cycle after rst releases, next block encrypts correctly.
